// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared definitions for the tile-side NoC injection logic.
//   arb_state_e : injection arbiter FSM states
//   Port*       : mesh router port indices
//   noc_pkt_t   : packet layout at the default router widths
//   wrap_inc    : modulo-n increment used for round-robin pointers
package noc_local_inject_arbiter_pkg;

  typedef enum logic {
    ArbIdle,
    ArbBurst
  } arb_state_e;

  localparam int unsigned PortNorth = 0;
  localparam int unsigned PortEast  = 1;
  localparam int unsigned PortSouth = 2;
  localparam int unsigned PortWest  = 3;
  localparam int unsigned PortLocal = 4;
  localparam int unsigned NumPorts  = 5;

  localparam int unsigned NocDataWidth = 32;
  localparam int unsigned NocAddrWidth = 8;

  typedef struct packed {
    logic [NocAddrWidth-1:0] addr;
    logic [NocDataWidth-1:0] data;
  } noc_pkt_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_local_inject_arbiter_if.sv
// Handshake bundle between on-tile requesters, the injection arbiter and the
// router local input port.
//   req_valid/req_data/req_addr/req_mask : requester side, into the arbiter
//   req_ready                            : one-hot accept strobe, out of the arbiter
//   out_valid/out_data/out_addr          : to the router local input
//   out_ready                            : from the router local input
//   owner_id/busy                        : arbiter status
// The arbiter uses the slave modport; the requester/router side uses master.
interface noc_local_inject_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned ID_WIDTH = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            req_mask;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [ADDR_WIDTH-1:0]       out_addr;
  logic                        out_ready;
  logic [ID_WIDTH-1:0]         owner_id;
  logic                        busy;

  modport slave (
    input  req_valid, req_data, req_addr, req_mask, out_ready,
    output req_ready, out_valid, out_data, out_addr, owner_id, busy
  );

  modport master (
    output req_valid, req_data, req_addr, req_mask, out_ready,
    input  req_ready, out_valid, out_data, out_addr, owner_id, busy
  );

endinterface

// File: rtl/noc_local_inject_arbiter_rr_pick.sv
// Combinational cyclic priority picker.
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < N)
//   gnt_o   : one-hot grant of the first set request at or after ptr_i, wrapping
//   idx_o   : binary index of that grant
//   found_o : any request set
module noc_local_inject_arbiter_rr_pick #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] idx_o,
  output logic           found_o
);

  always_comb begin
    logic        hit;
    int unsigned j;
    hit     = 1'b0;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!hit && req_i[j]) begin
        hit      = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdW'(j);
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Shares the router's single local injection port among N_REQ on-tile
// requesters with burst-limited round-robin arbitration. Accepted packets go
// through one registered output slot that feeds the router local input.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   bus_io : requester handshake, router-side output slot and status
//            (see noc_local_inject_arbiter_if)
module noc_local_inject_arbiter
  import noc_local_inject_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  noc_local_inject_arbiter_if.slave   bus_io
);

  localparam int unsigned ID_WIDTH = $clog2(N_REQ);
  localparam int unsigned CntW     = $clog2(BURST_MAX + 1);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      pick_gnt;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_found;
  logic [N_REQ-1:0]      req_ready;
  logic [ID_WIDTH-1:0]   acc_idx;
  logic                  accept;
  logic                  slot_free;

  assign eligible  = bus_io.req_valid & bus_io.req_mask;
  // The slot can take a new packet if empty or draining this cycle.
  assign slot_free = !out_valid_q || bus_io.out_ready;

  noc_local_inject_arbiter_rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Arbitration FSM: next state, grant and accept strobe.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    acc_idx   = owner_q;
    req_ready = '0;

    // Gating on rst keeps req_ready low while reset is held, since the
    // combinational grant would otherwise see an empty slot and valid inputs.
    if (!rst && slot_free) begin
      unique case (state_q)
        ArbIdle: begin
          if (pick_found) begin
            accept    = 1'b1;
            acc_idx   = pick_idx;
            req_ready = pick_gnt;
            owner_d   = pick_idx;
            cnt_d     = CntW'(1);
            if (BURST_MAX == 1) begin
              rr_ptr_d = ID_WIDTH'(wrap_inc(32'(pick_idx), N_REQ));
            end else begin
              state_d = ArbBurst;
            end
          end
        end
        ArbBurst: begin
          if (eligible[owner_q]) begin
            accept             = 1'b1;
            req_ready[owner_q] = 1'b1;
            cnt_d              = cnt_q + 1'b1;
            if (cnt_d == CntW'(BURST_MAX)) begin
              rr_ptr_d = ID_WIDTH'(wrap_inc(32'(owner_q), N_REQ));
              state_d  = ArbIdle;
            end
          end else begin
            // Owner dropped out (invalid or masked): give up the rest of the burst.
            rr_ptr_d = ID_WIDTH'(wrap_inc(32'(owner_q), N_REQ));
            state_d  = ArbIdle;
          end
        end
        default: state_d = ArbIdle;
      endcase
    end
  end

  // Output slot next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus_io.req_data[acc_idx*DATA_WIDTH +: DATA_WIDTH];
      out_addr_d  = bus_io.req_addr[acc_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ArbIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign bus_io.req_ready = req_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_addr  = out_addr_q;
  assign bus_io.owner_id  = owner_q;
  assign bus_io.busy      = (state_q == ArbBurst) || out_valid_q;

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Drives two arbiters (BURST_MAX=4 and BURST_MAX=2) with identical stimulus and
// checks both against a grant-budget reference model, plus fixed vectors and
// directed corner-case sequences.
module tb_noc_local_inject_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   tb_valid;
  logic [3:0]   tb_mask;
  logic         tb_ordy;
  logic [127:0] tb_data;
  logic [31:0]  tb_addr;

  always #5 clk = ~clk;

  noc_local_inject_arbiter_if #(.N_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) bus4 ();
  noc_local_inject_arbiter_if #(.N_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) bus2 ();

  assign bus4.req_valid = tb_valid;
  assign bus4.req_mask  = tb_mask;
  assign bus4.req_data  = tb_data;
  assign bus4.req_addr  = tb_addr;
  assign bus4.out_ready = tb_ordy;
  assign bus2.req_valid = tb_valid;
  assign bus2.req_mask  = tb_mask;
  assign bus2.req_data  = tb_data;
  assign bus2.req_addr  = tb_addr;
  assign bus2.out_ready = tb_ordy;

  noc_local_inject_arbiter #(
    .N_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .BURST_MAX(4)
  ) dut4 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus4.slave)
  );

  noc_local_inject_arbiter #(
    .N_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .BURST_MAX(2)
  ) dut2 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus2.slave)
  );

  typedef struct packed {
    logic [3:0]  rdy;
    logic        ov;
    logic [31:0] od;
    logic [7:0]  oa;
    logic [1:0]  own;
    logic        busy;
  } dout_t;

  dout_t obs [2];
  assign obs[0] = {bus4.req_ready, bus4.out_valid, bus4.out_data, bus4.out_addr,
                   bus4.owner_id, bus4.busy};
  assign obs[1] = {bus2.req_ready, bus2.out_valid, bus2.out_data, bus2.out_addr,
                   bus2.owner_id, bus2.busy};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a granted requester has a budget of packets left; a
  // budget of zero means the next accept is a fresh round-robin search.
  int          bmax   [2] = '{4, 2};
  int          m_ptr  [2];
  int          m_owner[2];
  int          m_left [2];
  logic        m_ov   [2];
  logic [31:0] m_od   [2];
  logic [7:0]  m_oa   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_owner[k] = 0; m_left[k] = 0;
      m_ov[k] = 1'b0; m_od[k] = '0; m_oa[k] = '0;
    end
  endtask

  task automatic new_data();
    tb_data = {$urandom, $urandom, $urandom, $urandom};
    tb_addr = $urandom;
  endtask

  // Called just after a rising edge with inputs already applied; checks both
  // DUTs against the model, then advances one clock.
  task automatic cycle();
    int          idx;
    int          nptr[2], nown[2], nleft[2];
    logic        nov[2];
    logic [31:0] nod[2];
    logic [7:0]  noa[2];
    logic [3:0]  elig, erdy;
    logic        free;
    #1;
    for (int k = 0; k < 2; k++) begin
      elig = tb_valid & tb_mask;
      free = !m_ov[k] || tb_ordy;
      idx  = -1;
      if (free) begin
        if (m_left[k] == 0) begin
          for (int j = 0; j < 4; j++) begin
            if (idx < 0 && elig[(m_ptr[k] + j) % 4]) idx = (m_ptr[k] + j) % 4;
          end
        end else if (elig[m_owner[k]]) begin
          idx = m_owner[k];
        end
      end
      erdy = '0;
      if (idx >= 0) erdy[idx] = 1'b1;
      chk($sformatf("b%0d req_ready", bmax[k]), 64'(obs[k].rdy), 64'(erdy));
      chk($sformatf("b%0d out_valid", bmax[k]), 64'(obs[k].ov), 64'(m_ov[k]));
      chk($sformatf("b%0d owner_id", bmax[k]), 64'(obs[k].own), 64'(m_owner[k]));
      chk($sformatf("b%0d busy", bmax[k]), 64'(obs[k].busy),
          64'((m_left[k] > 0) || m_ov[k]));
      if (m_ov[k]) begin
        chk($sformatf("b%0d out_data", bmax[k]), 64'(obs[k].od), 64'(m_od[k]));
        chk($sformatf("b%0d out_addr", bmax[k]), 64'(obs[k].oa), 64'(m_oa[k]));
      end
      nptr[k] = m_ptr[k]; nown[k] = m_owner[k]; nleft[k] = m_left[k];
      nov[k] = m_ov[k]; nod[k] = m_od[k]; noa[k] = m_oa[k];
      if (free) begin
        if (m_left[k] == 0) begin
          if (idx >= 0) begin
            nown[k]  = idx;
            nleft[k] = bmax[k] - 1;
            if (nleft[k] == 0) nptr[k] = (idx + 1) % 4;
          end
        end else if (idx >= 0) begin
          nleft[k] = m_left[k] - 1;
          if (nleft[k] == 0) nptr[k] = (m_owner[k] + 1) % 4;
        end else begin
          nleft[k] = 0;
          nptr[k]  = (m_owner[k] + 1) % 4;
        end
      end
      if (idx >= 0) begin
        nov[k] = 1'b1;
        nod[k] = tb_data[idx*32 +: 32];
        noa[k] = tb_addr[idx*8 +: 8];
      end else if (tb_ordy) begin
        nov[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = nptr[k]; m_owner[k] = nown[k]; m_left[k] = nleft[k];
      m_ov[k] = nov[k]; m_od[k] = nod[k]; m_oa[k] = noa[k];
    end
    new_data();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s b%0d req_ready", tag, bmax[k]), 64'(obs[k].rdy), 64'(0));
      chk($sformatf("%s b%0d out_valid", tag, bmax[k]), 64'(obs[k].ov), 64'(0));
      chk($sformatf("%s b%0d busy", tag, bmax[k]), 64'(obs[k].busy), 64'(0));
    end
  endtask

  // Assert reset with all requesters valid, check outputs, release after an edge.
  task automatic reset_seq();
    rst = 1'b1;
    tb_valid = 4'hF;
    tb_mask  = 4'hF;
    tb_ordy  = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    check_reset_outputs("reset held");
    rst = 1'b0;
    model_reset();
    new_data();
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] mask;
    logic       ordy;
    logic [3:0] rdy;
    logic [1:0] owner;
    logic       ov;
    logic       busy;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] held_data;
  logic [7:0]  held_addr;
  int          fair_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  logic [3:0]  exp_rdy;

  initial begin
    // Single requester 2 with BURST_MAX=4, then 5 cycles of backpressure.
    tbl[0]  = '{4'b0100, 4'hF, 1'b1, 4'b0100, 2'd0, 1'b0, 1'b0};
    for (int i = 1; i < 8; i++) tbl[i] = '{4'b0100, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
    for (int i = 8; i < 13; i++) tbl[i] = '{4'b0100, 4'hF, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1};
    tbl[13] = '{4'b0100, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};

    rst = 1'b1;
    tb_valid = '0; tb_mask = '0; tb_ordy = 1'b0;
    new_data();
    model_reset();
    @(posedge clk);
    #1;
    reset_seq();

    held_data = '0;
    held_addr = '0;
    for (int i = 0; i < 14; i++) begin
      tb_valid = tbl[i].valid;
      tb_mask  = tbl[i].mask;
      tb_ordy  = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d req_ready", i), 64'(bus4.req_ready), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d owner_id", i), 64'(bus4.owner_id), 64'(tbl[i].owner));
      chk($sformatf("vec%0d out_valid", i), 64'(bus4.out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d busy", i), 64'(bus4.busy), 64'(tbl[i].busy));
      if (i == 8) begin
        held_data = bus4.out_data;
        held_addr = bus4.out_addr;
      end else if (i > 8 && i < 13) begin
        chk($sformatf("vec%0d stall data", i), 64'(bus4.out_data), 64'(held_data));
        chk($sformatf("vec%0d stall addr", i), 64'(bus4.out_addr), 64'(held_addr));
      end
      cycle();
    end

    // Fairness with BURST_MAX=2: pairs of grants in round-robin order.
    reset_seq();
    tb_valid = 4'hF; tb_mask = 4'hF; tb_ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_rdy = 4'b0001 << fair_seq[i];
      chk($sformatf("fair grant %0d", i), 64'(bus2.req_ready), 64'(exp_rdy));
      if (i > 0) chk($sformatf("fair out_valid %0d", i), 64'(bus2.out_valid), 64'(1));
      cycle();
    end

    // Early release: owner 1 drops after one packet; pointer moves past it.
    reset_seq();
    tb_valid = 4'b0010;
    #1;
    chk("early first grant", 64'(bus4.req_ready), 64'(4'b0010));
    cycle();
    tb_valid = 4'b1000;
    #1;
    chk("early bubble ready", 64'(bus4.req_ready), 64'(0));
    chk("early bubble busy", 64'(bus4.busy), 64'(1));
    cycle();
    tb_valid = 4'b1010;
    #1;
    chk("early regrant", 64'(bus4.req_ready), 64'(4'b1000));
    cycle();
    #1;
    chk("early new owner", 64'(bus4.owner_id), 64'(3));
    cycle();

    // Masking: requester 2 disabled must never be granted.
    reset_seq();
    tb_valid = 4'hF; tb_mask = 4'b1011;
    for (int i = 0; i < 24; i++) begin
      #1;
      chk("mask b4 no grant 2", 64'(bus4.req_ready[2]), 64'(0));
      chk("mask b2 no grant 2", 64'(bus2.req_ready[2]), 64'(0));
      cycle();
    end

    // Masking the owner mid-burst releases the grant.
    reset_seq();
    tb_valid = 4'hF; tb_mask = 4'hF;
    #1;
    chk("mask burst first", 64'(bus4.req_ready), 64'(4'b0001));
    cycle();
    #1;
    chk("mask burst second", 64'(bus4.req_ready), 64'(4'b0001));
    cycle();
    tb_mask = 4'b1110;
    #1;
    chk("mask release ready", 64'(bus4.req_ready), 64'(0));
    cycle();
    #1;
    chk("mask next owner", 64'(bus4.req_ready), 64'(4'b0010));
    cycle();

    // Reset in the middle of a burst clears the slot without waiting for an edge.
    reset_seq();
    tb_valid = 4'hF; tb_mask = 4'hF; tb_ordy = 1'b1;
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-burst reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    new_data();

    // Randomized traffic against the model.
    tb_mask = 4'hF;
    for (int i = 0; i < 1500; i++) begin
      tb_valid = 4'($urandom);
      tb_ordy  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) tb_mask = 4'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
